uart_regfile: RTL and testbench
===============================

// Module: uart_regfile
// PURPOSE
//  Register file downstream of the APB slave: decodes its waddr/wdata/raddr strobes into UART control regs.
//  Buffers TX bytes for the transmitter and RX bytes from the receiver in two sync FIFOs.
//  Returns read data combinationally and reports address validity for PSLVERR generation.
// PARAMETERS
//  TX_DEPTH      16       TX FIFO entries; power of 2, 2..128
//  RX_DEPTH      16       RX FIFO entries; power of 2, 2..128
//  BAUD_DIV_RST  16'd868  BAUD register reset value
// PORTS
//  pclk        in   1   clock; single clock domain
//  preset      in   1   synchronous, active-high reset
//  waddr       in   12  write address from APB slave
//  wdata       in   32  write data from APB slave
//  pwrite_i    in   1   write strobe (APB slave pwrite_o)
//  raddr       in   12  read address from APB slave
//  host_read   in   1   read strobe (APB slave host_read_data)
//  rdata       out  32  read data, combinational from raddr
//  wadderr     out  1   1 = write addr legal or no write active; 0 = illegal write
//  radderr     out  1   1 = read addr legal or no read active; 0 = illegal read
//  tx_data     out  8   TX FIFO head
//  tx_valid    out  1   TX FIFO non-empty and CTRL.tx_en
//  tx_ready    in   1   transmitter accepts head when tx_valid&tx_ready
//  rx_data     in   8   received byte
//  rx_valid    in   1   1-cycle push; no backpressure
//  tx_en, rx_en out 1   CTRL[0], CTRL[1]
//  parity      out  2   CTRL[3:2]
//  stop2       out  1   CTRL[4]
//  baud_div    out  16  BAUD[15:0]
// BEHAVIOUR
//  Decode on addr[11:2]; addr[1:0] ignored. Map:
//   0x000 TXDATA W: push wdata[7:0]. 0x004 RXDATA R: {24'h0,head}, pop.
//   0x008 STATUS R: [0]tx_full [1]tx_empty [2]rx_full [3]rx_empty [4]tx_ovf [5]rx_ovf [15:8]tx_cnt [23:16]rx_cnt.
//   0x00C CTRL RW [4:0]. 0x010 BAUD RW [15:0]. 0x014 CLEAR W: [4]/[5] clr tx_ovf/rx_ovf, [8]/[9] flush TX/RX.
//  Strobes edge-detected: a write commits, and an RXDATA pop occurs, only in the first cycle the strobe is high.
//   Strobes held multiple cycles act once.
//  Writes to read-only addrs and reads of write-only addrs are illegal; unmapped addrs are illegal.
//   Illegal accesses have no side effect. wadderr/radderr go 0 combinationally in the strobe cycle.
//  rdata = 0 for illegal or unmapped reads. RXDATA read when empty returns 0; no pop, no flag.
//  TX push when full is dropped and tx_ovf set, unless a pop occurs the same cycle; then the push is accepted.
//  RX push when full is dropped and rx_ovf set, unless a host pop occurs the same cycle; then the push is accepted.
//  ovf flags are sticky until CLEAR; a set in the same cycle as a clear wins.
//  Flush empties the FIFO next cycle; a push in the flush cycle is dropped and does not set ovf.
//  Pointers wrap mod DEPTH; count width $clog2(DEPTH)+1, zero-extended to 8 bits.
//  Reset: FIFOs empty, ovf=0, CTRL=0, BAUD=BAUD_DIV_RST. Outputs: tx_valid=0, tx_en=rx_en=0,
//   parity=0, stop2=0, wadderr=radderr=1, rdata=0, tx_data=0.
//  Reset mid-operation discards all FIFO contents.
// CONFIGURATION
//  UART_REGFILE_IRQ_EN defined:
//   - adds port irq (out, 1) and IER at 0x018 RW [3:0].
//   - irq = |(IER & {rx_ovf|tx_ovf, rx_full, ~rx_empty, tx_empty}); registered, one-cycle latency, reset 0.
//  Undefined: no irq port; 0x018 is unmapped (illegal).
// STRUCTURE
//  uart_pkg: address localparams, STATUS/CTRL bit indices, packed ctrl_t struct.
//  Sub-module uart_sync_fifo #(WIDTH,DEPTH), instanced for TX and RX:
//   push/pop/flush, full/empty/count, head data.
// TESTING
//  Reset, then read 0x010 -> rdata=0x364, radderr=1; read 0x008 -> 0x0000_000A.
//  Write 0x00C=0x13 -> tx_en=1, rx_en=1, parity=0, stop2=1; read back 0x13.
//  17 TXDATA writes with tx_ready=0 -> tx_cnt=16, tx_ovf=1; first 16 bytes drain in order.
//  rx_valid with 0xA5 then 0x3C; two RXDATA reads -> 0xA5, 0x3C; third read -> 0, rx_empty=1.
//  Write to 0x008 -> wadderr=0, STATUS unchanged; read 0x7FC -> radderr=0, rdata=0.
//  Full RX, rx_valid in the same cycle as a pop -> push accepted, rx_ovf stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS/CLEAR bit positions and the CTRL layout
// shared by the UART register file and its FIFOs.
package uart_pkg;

  localparam logic [11:0] A_TXDATA = 12'h000;
  localparam logic [11:0] A_RXDATA = 12'h004;
  localparam logic [11:0] A_STATUS = 12'h008;
  localparam logic [11:0] A_CTRL   = 12'h00C;
  localparam logic [11:0] A_BAUD   = 12'h010;
  localparam logic [11:0] A_CLEAR  = 12'h014;
  localparam logic [11:0] A_IER    = 12'h018;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_OVF   = 5;
  localparam int ST_TX_CNT   = 8;
  localparam int ST_RX_CNT   = 16;

  localparam int CLR_TX_OVF   = 4;
  localparam int CLR_RX_OVF   = 5;
  localparam int CLR_TX_FLUSH = 8;
  localparam int CLR_RX_FLUSH = 9;

  typedef struct packed {
    logic       stop2;
    logic [1:0] parity;
    logic       rx_en;
    logic       tx_en;
  } ctrl_t;

  // Word-address match: byte offset bits [1:0] are masked out.
  function automatic logic hit(input logic [11:0] a,
                               input logic [11:0] r);
    return ((a ^ r) & 12'hFFC) == 12'h000;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with push/pop/flush, full/empty/count.
// Ports: clk_i, rst_i (sync, high), push_i, pop_i, flush_i, wdata_i,
//   rdata_o (head, 0 when empty), full_o, empty_o, count_o, ovf_o.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovf_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  // A pop in the same cycle frees a slot, so a push into a full FIFO
  // is still accepted. Flush overrides both and never flags overflow.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;
  assign ovf_o   = push_i & full_o & ~do_pop & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/uart_regfile.sv
// uart_regfile: APB-side UART register file with TX/RX byte FIFOs.
// Ports: pclk/preset, write (waddr,wdata,pwrite_i), read (raddr,host_read,
//   rdata), address status (wadderr,radderr), TX stream (tx_data,tx_valid,
//   tx_ready), RX push (rx_data,rx_valid), CTRL/BAUD fields.
//   UART_REGFILE_IRQ_EN adds IER at 0x018 and a registered irq output.
module uart_regfile
  import uart_pkg::*;
#(
  parameter int          TX_DEPTH     = 16,
  parameter int          RX_DEPTH     = 16,
  parameter logic [15:0] BAUD_DIV_RST = 16'd868
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic [11:0] waddr,
  input  logic [31:0] wdata,
  input  logic        pwrite_i,
  input  logic [11:0] raddr,
  input  logic        host_read,
  output logic [31:0] rdata,
  output logic        wadderr,
  output logic        radderr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        tx_en,
  output logic        rx_en,
  output logic [1:0]  parity,
  output logic        stop2,
  output logic [15:0] baud_div
`ifdef UART_REGFILE_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int TXC = $clog2(TX_DEPTH) + 1;
  localparam int RXC = $clog2(RX_DEPTH) + 1;

  ctrl_t           ctrl_q;
  logic [15:0]     baud_q;
  logic            tx_ovf_q, tx_ovf_d;
  logic            rx_ovf_q, rx_ovf_d;
  logic            wr_q, rd_q;
  logic            wr_fire, rd_fire;
  logic            w_ok, r_ok;
  logic            we_tx, we_ctrl, we_baud, we_clr;
  logic            tx_pop, tx_full, tx_empty, tx_set;
  logic            rx_pop, rx_full, rx_empty, rx_set;
  logic [7:0]      tx_head, rx_head;
  logic [TXC-1:0]  tx_cnt;
  logic [RXC-1:0]  rx_cnt;
  logic [31:0]     status;
  logic [15:0]     unused_wdata;

  assign unused_wdata = wdata[31:16];

`ifdef UART_REGFILE_IRQ_EN
  logic [3:0] ier_q;
  logic       irq_q, irq_d;
  logic       we_ier;
`endif

  always_comb begin
    w_ok = hit(waddr, A_TXDATA) | hit(waddr, A_CTRL) |
           hit(waddr, A_BAUD)   | hit(waddr, A_CLEAR);
    r_ok = hit(raddr, A_RXDATA) | hit(raddr, A_STATUS) |
           hit(raddr, A_CTRL)   | hit(raddr, A_BAUD);
`ifdef UART_REGFILE_IRQ_EN
    w_ok = w_ok | hit(waddr, A_IER);
    r_ok = r_ok | hit(raddr, A_IER);
`endif
  end

  // Strobes act only in their first high cycle.
  assign wr_fire = pwrite_i & ~wr_q;
  assign rd_fire = host_read & ~rd_q;
  assign wadderr = ~(pwrite_i & ~w_ok);
  assign radderr = ~(host_read & ~r_ok);

  assign we_tx   = wr_fire & hit(waddr, A_TXDATA);
  assign we_ctrl = wr_fire & hit(waddr, A_CTRL);
  assign we_baud = wr_fire & hit(waddr, A_BAUD);
  assign we_clr  = wr_fire & hit(waddr, A_CLEAR);
`ifdef UART_REGFILE_IRQ_EN
  assign we_ier  = wr_fire & hit(waddr, A_IER);
`endif

  assign tx_valid = ~tx_empty & ctrl_q.tx_en;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_data  = tx_head;
  assign rx_pop   = rd_fire & hit(raddr, A_RXDATA);

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i   (pclk),
    .rst_i   (preset),
    .push_i  (we_tx),
    .pop_i   (tx_pop),
    .flush_i (we_clr & wdata[CLR_TX_FLUSH]),
    .wdata_i (wdata[7:0]),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_cnt),
    .ovf_o   (tx_set)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (pclk),
    .rst_i   (preset),
    .push_i  (rx_valid),
    .pop_i   (rx_pop),
    .flush_i (we_clr & wdata[CLR_RX_FLUSH]),
    .wdata_i (rx_data),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_cnt),
    .ovf_o   (rx_set)
  );

  // Sticky flags: a new overflow beats a same-cycle clear.
  assign tx_ovf_d = (tx_ovf_q & ~(we_clr & wdata[CLR_TX_OVF])) | tx_set;
  assign rx_ovf_d = (rx_ovf_q & ~(we_clr & wdata[CLR_RX_OVF])) | rx_set;

  always_comb begin
    status = '0;
    status[ST_TX_FULL]      = tx_full;
    status[ST_TX_EMPTY]     = tx_empty;
    status[ST_RX_FULL]      = rx_full;
    status[ST_RX_EMPTY]     = rx_empty;
    status[ST_TX_OVF]       = tx_ovf_q;
    status[ST_RX_OVF]       = rx_ovf_q;
    status[ST_TX_CNT +: 8]  = 8'(tx_cnt);
    status[ST_RX_CNT +: 8]  = 8'(rx_cnt);
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit(raddr, A_RXDATA): rdata = {24'h0, rx_head};
      hit(raddr, A_STATUS): rdata = status;
      hit(raddr, A_CTRL):   rdata = {27'h0, ctrl_q};
      hit(raddr, A_BAUD):   rdata = {16'h0, baud_q};
`ifdef UART_REGFILE_IRQ_EN
      hit(raddr, A_IER):    rdata = {28'h0, ier_q};
`endif
      default:              rdata = '0;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      ctrl_q   <= '0;
      baud_q   <= BAUD_DIV_RST;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      wr_q     <= pwrite_i;
      rd_q     <= host_read;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      if (we_ctrl) ctrl_q <= ctrl_t'(wdata[4:0]);
      if (we_baud) baud_q <= wdata[15:0];
    end
  end

  assign tx_en    = ctrl_q.tx_en;
  assign rx_en    = ctrl_q.rx_en;
  assign parity   = ctrl_q.parity;
  assign stop2    = ctrl_q.stop2;
  assign baud_div = baud_q;

`ifdef UART_REGFILE_IRQ_EN
  assign irq_d = |(ier_q & {rx_ovf_q | tx_ovf_q, rx_full,
                            ~rx_empty, tx_empty});

  always_ff @(posedge pclk) begin
    if (preset) begin
      ier_q <= '0;
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
      if (we_ier) ier_q <= wdata[3:0];
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_regfile.sv
// tb_uart_regfile: directed stimulus with queued expectations; a negedge
// monitor compares reads, write address status and TX handshakes.
module tb_uart_regfile;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [11:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic        pwrite_i = 1'b0;
  logic [11:0] raddr = '0;
  logic        host_read = 1'b0;
  logic [31:0] rdata;
  logic        wadderr, radderr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_en, rx_en, stop2;
  logic [1:0]  parity;
  logic [15:0] baud_div;
`ifdef UART_REGFILE_IRQ_EN
  logic        irq;
`endif

  uart_regfile dut (
    .pclk      (pclk),
    .preset    (preset),
    .waddr     (waddr),
    .wdata     (wdata),
    .pwrite_i  (pwrite_i),
    .raddr     (raddr),
    .host_read (host_read),
    .rdata     (rdata),
    .wadderr   (wadderr),
    .radderr   (radderr),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_en     (tx_en),
    .rx_en     (rx_en),
    .parity    (parity),
    .stop2     (stop2),
    .baud_div  (baud_div)
`ifdef UART_REGFILE_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } rexp_t;

  rexp_t      rq[$];
  logic       wq[$];
  logic [7:0] tq[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic       hr_prev = 1'b0;
  logic       pw_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic bad(input string nm);
    total_cnt++;
    $display("FAIL %s: got no expectation/event expected one", nm);
  endtask

  always @(negedge pclk) begin
    if (!preset) begin
      if (host_read && !hr_prev) begin
        if (rq.size() == 0) bad("rd_unexpected");
        else begin
          rexp_t r;
          r = rq.pop_front();
          chk("rdata", rdata, r.d);
          chk("radderr", {31'h0, radderr}, {31'h0, r.e});
        end
      end
      if (pwrite_i && !pw_prev) begin
        if (wq.size() == 0) bad("wr_unexpected");
        else chk("wadderr", {31'h0, wadderr}, {31'h0, wq.pop_front()});
      end
      if (tx_valid && tx_ready) begin
        if (tq.size() == 0) bad("tx_extra");
        else chk("tx_data", {24'h0, tx_data}, {24'h0, tq.pop_front()});
      end
    end
    hr_prev = host_read;
    pw_prev = pwrite_i;
  end

  task automatic rd(input logic [11:0] a, input logic [31:0] d,
                    input logic e);
    @(posedge pclk); #1;
    rq.push_back('{d: d, e: e});
    raddr = a;
    host_read = 1'b1;
    @(posedge pclk); #1;
    host_read = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d,
                    input logic e);
    @(posedge pclk); #1;
    wq.push_back(e);
    waddr = a;
    wdata = d;
    pwrite_i = 1'b1;
    @(posedge pclk); #1;
    pwrite_i = 1'b0;
  endtask

  task automatic rxp(input logic [7:0] b);
    @(posedge pclk); #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge pclk); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;

    // Reset state
    @(negedge pclk);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_en", {31'h0, tx_en}, 32'h0);
    chk("rst_rx_en", {31'h0, rx_en}, 32'h0);
    chk("rst_parity", {30'h0, parity}, 32'h0);
    chk("rst_stop2", {31'h0, stop2}, 32'h0);
    chk("rst_wadderr", {31'h0, wadderr}, 32'h1);
    chk("rst_radderr", {31'h0, radderr}, 32'h1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_baud", {16'h0, baud_div}, 32'h364);
    rd(12'h010, 32'h0000_0364, 1'b1);
    rd(12'h008, 32'h0000_000A, 1'b1);

    // CTRL
    wr(12'h00C, 32'h13, 1'b1);
    @(negedge pclk);
    chk("ctrl_tx_en", {31'h0, tx_en}, 32'h1);
    chk("ctrl_rx_en", {31'h0, rx_en}, 32'h1);
    chk("ctrl_parity", {30'h0, parity}, 32'h0);
    chk("ctrl_stop2", {31'h0, stop2}, 32'h1);
    rd(12'h00C, 32'h13, 1'b1);

    // TX fill past full, then drain in order
    for (int i = 0; i < 17; i++) wr(12'h000, 32'(8'h10 + i), 1'b1);
    rd(12'h008, 32'h0000_1019, 1'b1);
    @(negedge pclk);
    chk("tx_valid_full", {31'h0, tx_valid}, 32'h1);
    @(posedge pclk); #1;
    for (int i = 0; i < 16; i++) tq.push_back(8'(8'h10 + i));
    tx_ready = 1'b1;
    n = 0;
    while (tq.size() != 0 && n < 50) begin
      @(posedge pclk);
      n++;
    end
    #1 tx_ready = 1'b0;
    if (n >= 50) bad("tx_drain_timeout");
    rd(12'h008, 32'h0000_001A, 1'b1);
    wr(12'h014, 32'h10, 1'b1);
    rd(12'h008, 32'h0000_000A, 1'b1);

    // RX basic
    rxp(8'hA5);
    rxp(8'h3C);
    rd(12'h008, 32'h0002_0002, 1'b1);
    rd(12'h004, 32'hA5, 1'b1);
    rd(12'h004, 32'h3C, 1'b1);
    rd(12'h004, 32'h0, 1'b1);
    rd(12'h008, 32'h0000_000A, 1'b1);

    // Held read strobe pops once
    rxp(8'h11);
    rxp(8'h22);
    @(posedge pclk); #1;
    rq.push_back('{d: 32'h11, e: 1'b1});
    raddr = 12'h004;
    host_read = 1'b1;
    repeat (3) @(posedge pclk);
    #1 host_read = 1'b0;
    rd(12'h004, 32'h22, 1'b1);
    rd(12'h008, 32'h0000_000A, 1'b1);

    // Illegal and byte-offset accesses
    wr(12'h008, 32'hFFFF_FFFF, 1'b0);
    rd(12'h008, 32'h0000_000A, 1'b1);
    rd(12'h7FC, 32'h0, 1'b0);
    rd(12'h000, 32'h0, 1'b0);
    wr(12'h004, 32'h55, 1'b0);
    wr(12'h7FC, 32'h55, 1'b0);
`ifdef UART_REGFILE_IRQ_EN
    rd(12'h018, 32'h0, 1'b1);
`else
    rd(12'h018, 32'h0, 1'b0);
`endif
    rd(12'h013, 32'h364, 1'b1);
    wr(12'h010, 32'hABCD_1234, 1'b1);
    rd(12'h012, 32'h1234, 1'b1);
    rd(12'h008, 32'h0000_000A, 1'b1);

    // RX full with same-cycle pop, then real overflow
    for (int i = 0; i < 16; i++) rxp(8'(8'h40 + i));
    rd(12'h008, 32'h0010_0006, 1'b1);
    @(posedge pclk); #1;
    rq.push_back('{d: 32'h40, e: 1'b1});
    raddr = 12'h004;
    host_read = 1'b1;
    rx_data = 8'h99;
    rx_valid = 1'b1;
    @(posedge pclk); #1;
    host_read = 1'b0;
    rx_valid = 1'b0;
    rd(12'h008, 32'h0010_0006, 1'b1);
    rxp(8'h77);
    rd(12'h008, 32'h0010_0026, 1'b1);
    for (int i = 1; i < 16; i++) rd(12'h004, 32'(8'h40 + i), 1'b1);
    rd(12'h004, 32'h99, 1'b1);
    rd(12'h008, 32'h0000_002A, 1'b1);

    // Flush with same-cycle push: dropped, no overflow
    rxp(8'h01);
    rxp(8'h02);
    @(posedge pclk); #1;
    wq.push_back(1'b1);
    waddr = 12'h014;
    wdata = 32'h220;
    pwrite_i = 1'b1;
    rx_data = 8'h03;
    rx_valid = 1'b1;
    @(posedge pclk); #1;
    pwrite_i = 1'b0;
    rx_valid = 1'b0;
    rd(12'h008, 32'h0000_000A, 1'b1);

    // Overflow set beats same-cycle clear
    for (int i = 0; i < 16; i++) rxp(8'(8'h50 + i));
    @(posedge pclk); #1;
    wq.push_back(1'b1);
    waddr = 12'h014;
    wdata = 32'h20;
    pwrite_i = 1'b1;
    rx_data = 8'hEE;
    rx_valid = 1'b1;
    @(posedge pclk); #1;
    pwrite_i = 1'b0;
    rx_valid = 1'b0;
    rd(12'h008, 32'h0010_0026, 1'b1);
    wr(12'h014, 32'h220, 1'b1);
    rd(12'h008, 32'h0000_000A, 1'b1);

    // Reset mid-operation
    rxp(8'hAA);
    wr(12'h000, 32'h61, 1'b1);
    wr(12'h000, 32'h62, 1'b1);
    @(posedge pclk); #1;
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    chk("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("mid_rst_tx_en", {31'h0, tx_en}, 32'h0);
    rd(12'h008, 32'h0000_000A, 1'b1);
    rd(12'h00C, 32'h0, 1'b1);
    rd(12'h010, 32'h364, 1'b1);

    // Held write strobe pushes once
    @(posedge pclk); #1;
    wq.push_back(1'b1);
    waddr = 12'h000;
    wdata = 32'h5A;
    pwrite_i = 1'b1;
    repeat (3) @(posedge pclk);
    #1 pwrite_i = 1'b0;
    rd(12'h008, 32'h0000_0108, 1'b1);

    repeat (3) @(posedge pclk);
    chk("rd_queue_left", 32'(rq.size()), 32'h0);
    chk("wr_queue_left", 32'(wq.size()), 32'h0);
    chk("tx_queue_left", 32'(tq.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
